sb_config_loader: RTL

Loads the per-tile configuration word `c` of the CLB switch box from a narrow, word-wide configuration stream using a valid/ready handshake. Incoming words are assembled in a shadow register. The shadow register is committed atomically to the switch box's `c` input only when a full configuration has arrived, so the switch box never sees a partial configuration. One instance per tile sits between the configuration chain and `clb_switch_box`, driving its `c` and `cset` inputs.

---
 rtl/sb_cfg_pkg.sv | 20 ++
 rtl/sb_config_loader_if.sv | 11 +
 rtl/sb_cfg_shadow.sv | 41 ++++
 rtl/sb_config_loader.sv | 111 +++++++++++
 4 files changed

// File: rtl/sb_cfg_pkg.sv
// rtl/sb_cfg_pkg.sv - shared sizing helpers and loader state type for the switch-box config loader
package sb_cfg_pkg;

  // Switch-box configuration width: 8 bits per single wire, 8 per pair of doubles.
  function automatic int sb_cfg_width(input int ws, input int wd);
    return ws * 8 + (wd / 2) * 8;
  endfunction

  // Number of stream words needed to cover a full configuration (ceiling division).
  function automatic int sb_cfg_words(input int cw, input int word);
    return (cw + word - 1) / word;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } sb_cfg_state_e;

endpackage

// File: rtl/sb_config_loader_if.sv
// rtl/sb_config_loader_if.sv - word-wide valid/ready configuration stream
interface sb_config_loader_if #(
  parameter int WORD = 8
);
  logic [WORD-1:0] cfg_data;
  logic            cfg_valid;
  logic            cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/sb_cfg_shadow.sv
// rtl/sb_cfg_shadow.sv - indexed word-write shadow register with final-word truncation
module sb_cfg_shadow #(
  parameter int CW   = 80,
  parameter int WORD = 8,
  parameter int NW   = 10,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [CNTW-1:0] idx_i,
  input  logic [WORD-1:0] data_i,
  output logic [CW-1:0]   shadow_o
);

  logic [CW-1:0] shadow_q;
  logic [CW-1:0] shadow_d;

  // Each word slot owns a fixed bit range; the last slot is clipped at CW so
  // the excess high bits of the final word never reach the register.
  for (genvar k = 0; k < NW; k++) begin : g_word
    localparam int LO = k * WORD;
    localparam int HI = ((LO + WORD) > CW) ? CW : (LO + WORD);
    localparam int NB = HI - LO;

    assign shadow_d[HI-1:LO] = (we_i && (idx_i == CNTW'(k))) ? data_i[NB-1:0]
                                                             : shadow_q[HI-1:LO];
  end

  // Shadow storage; a reset discards any partially assembled configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/sb_config_loader.sv
// rtl/sb_config_loader.sv - assembles a switch-box config from a word stream and commits it atomically
module sb_config_loader
  import sb_cfg_pkg::*;
#(
  parameter  int WS   = 7,
  parameter  int WD   = 6,
  parameter  int WORD = 8,
  localparam int CW   = sb_cfg_width(WS, WD),
  localparam int NW   = sb_cfg_words(CW, WORD)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  sb_config_loader_if.slave         cfg,
  output logic [CW-1:0]             c,
  output logic                      cset,
  output logic                      busy,
  output logic                      done
);

  localparam int CNTW = $clog2(NW + 1);

  sb_cfg_state_e   state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   c_q;
  logic            cset_q;
  logic            done_q;
  logic            ready_q;
  logic            busy_q;
  logic            shadow_we;
  logic            commit;
  logic [CW-1:0]   shadow;

  sb_cfg_shadow #(
    .CW   (CW),
    .WORD (WORD),
    .NW   (NW),
    .CNTW (CNTW)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .we_i     (shadow_we),
    .idx_i    (cnt_q),
    .data_i   (cfg.cfg_data),
    .shadow_o (shadow)
  );

  // Next-state logic: start restarts a load and outranks an accept in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_we = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (start) begin
          cnt_d = '0;
        end else if (cfg.cfg_valid && ready_q) begin
          shadow_we = 1'b1;
          cnt_d     = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(NW - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; c only changes on the commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= '0;
      cset_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == LOAD);
      busy_q  <= (state_d != IDLE);
      done_q  <= commit;
      if (commit) begin
        c_q    <= shadow;
        cset_q <= 1'b1;
      end
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign c             = c_q;
  assign cset          = cset_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
